// File: rtl/conv_frame_ctrl_if.sv
// Pixel source, convolution-core and sink signals of conv_frame_ctrl.
// master: the environment (source, core, sink); slave: the controller.
interface conv_frame_ctrl_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 16
);
  logic                     src_valid;
  logic                     src_ready;
  logic [PIX_W-1:0]         src_data;
  logic                     conv_valid_in;
  logic [PIX_W-1:0]         conv_px_in;
  logic                     conv_kernel_wr;
  logic [3:0]               conv_kernel_addr;
  logic signed [COEF_W-1:0] conv_kernel_data;
  logic                     conv_valid_out;
  logic [PIX_W-1:0]         conv_px_out;
  logic                     snk_valid;
  logic [PIX_W-1:0]         snk_data;

  modport master (
    output src_valid, src_data, conv_valid_out, conv_px_out,
    input  src_ready, conv_valid_in, conv_px_in, conv_kernel_wr,
           conv_kernel_addr, conv_kernel_data, snk_valid, snk_data
  );

  modport slave (
    input  src_valid, src_data, conv_valid_out, conv_px_out,
    output src_ready, conv_valid_in, conv_px_in, conv_kernel_wr,
           conv_kernel_addr, conv_kernel_data, snk_valid, snk_data
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution core: kernel load, pixel stream, drain.
// Optional CONV_FRAME_CTRL_KDIRTY_EN skips the kernel load when the shadow is unchanged.
module conv_frame_ctrl #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned IMG_W     = 128,
  parameter int unsigned IMG_H     = 128,
  parameter int unsigned DRAIN_CYC = 16,
  parameter int unsigned CNT_W     = $clog2(IMG_W*IMG_H+1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  conv_frame_ctrl_if.slave         bus,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         in_cnt,
  output logic [CNT_W-1:0]         out_cnt
);
  localparam int unsigned TOTAL  = IMG_W * IMG_H;
  localparam int unsigned IDLE_W = $clog2(DRAIN_CYC + 1);
  localparam int unsigned NKER   = 9;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t                   state, state_d;
  logic signed [COEF_W-1:0] shadow [NKER];
  logic signed [COEF_W-1:0] snap   [NKER];
  logic [IDLE_W-1:0]        idle_cnt, idle_d;
  logic [CNT_W-1:0]         in_cnt_d, out_cnt_d;
  logic                     kwr_d;
  logic [3:0]               kaddr_d;
  logic signed [COEF_W-1:0] kdata_d;
  logic                     done_d, snap_en, accept, fwd, cfg_hit;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
  logic                     dirty, dirty_d;
`endif

  assign cfg_hit       = cfg_we && (cfg_addr <= 4'd8);
  assign bus.src_ready = (state == S_STREAM) && (in_cnt < CNT_W'(TOTAL));
  assign accept        = bus.src_valid && bus.src_ready;
  assign fwd           = bus.conv_valid_out && (state != S_IDLE);
  assign busy          = (state != S_IDLE);

  // Software-visible shadow kernel and the per-frame snapshot taken at start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NKER; i++) begin
        shadow[i] <= '0;
        snap[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NKER; i++) begin
        if (cfg_we && cfg_addr == 4'(i)) shadow[i] <= cfg_data;
        if (snap_en)                     snap[i]   <= shadow[i];
      end
    end
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d   = state;
    kwr_d     = 1'b0;
    kaddr_d   = bus.conv_kernel_addr;
    kdata_d   = bus.conv_kernel_data;
    done_d    = 1'b0;
    snap_en   = 1'b0;
    idle_d    = idle_cnt;
    in_cnt_d  = accept ? in_cnt + CNT_W'(1) : in_cnt;
    out_cnt_d = (fwd && out_cnt != '1) ? out_cnt + CNT_W'(1) : out_cnt;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
    dirty_d   = dirty | cfg_hit;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          snap_en   = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          idle_d    = '0;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
          dirty_d   = cfg_hit;
          if (dirty) begin
            state_d = S_LOAD;
            kwr_d   = 1'b1;
            kaddr_d = 4'd0;
            kdata_d = shadow[0];
          end else begin
            state_d = S_STREAM;
          end
`else
          state_d = S_LOAD;
          kwr_d   = 1'b1;
          kaddr_d = 4'd0;
          kdata_d = shadow[0];
`endif
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
          dirty_d = 1'b1;
`endif
        end else if (bus.conv_kernel_addr == 4'd8) begin
          state_d = S_STREAM;
        end else begin
          kwr_d   = 1'b1;
          kaddr_d = 4'(bus.conv_kernel_addr + 4'd1);
          kdata_d = snap[kaddr_d];
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && in_cnt == CNT_W'(TOTAL - 1)) begin
          state_d = S_DRAIN;
          idle_d  = '0;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          idle_d = bus.conv_valid_out ? '0 : idle_cnt + IDLE_W'(1);
          if (idle_d == IDLE_W'(DRAIN_CYC)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; an accepted pixel reaches the core even if aborted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= S_IDLE;
      bus.conv_valid_in    <= 1'b0;
      bus.conv_px_in       <= '0;
      bus.conv_kernel_wr   <= 1'b0;
      bus.conv_kernel_addr <= '0;
      bus.conv_kernel_data <= '0;
      bus.snk_valid        <= 1'b0;
      bus.snk_data         <= '0;
      done                 <= 1'b0;
      in_cnt               <= '0;
      out_cnt              <= '0;
      idle_cnt             <= '0;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
      dirty                <= 1'b1;
`endif
    end else begin
      state                <= state_d;
      bus.conv_valid_in    <= accept;
      if (accept) bus.conv_px_in <= bus.src_data;
      bus.conv_kernel_wr   <= kwr_d;
      bus.conv_kernel_addr <= kaddr_d;
      bus.conv_kernel_data <= kdata_d;
      bus.snk_valid        <= fwd;
      if (fwd) bus.snk_data <= bus.conv_px_out;
      done                 <= done_d;
      in_cnt               <= in_cnt_d;
      out_cnt              <= out_cnt_d;
      idle_cnt             <= idle_d;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
      dirty                <= dirty_d;
`endif
    end
  end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed self-checking bench for conv_frame_ctrl on a 4x4 frame, DRAIN_CYC=16.
// Kernel-load skipping is exercised when CONV_FRAME_CTRL_KDIRTY_EN is defined.
module tb_conv_frame_ctrl;
  localparam int unsigned PIX_W = 8, COEF_W = 16, IMG_W = 4, IMG_H = 4;
  localparam int unsigned DRAIN_CYC = 16, CNT_W = 5;

  logic              clk = 1'b0;
  logic              rstn, start, abort, cfg_we;
  logic [3:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              busy, done;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  int                errors = 0;
  int                checks = 0;

  conv_frame_ctrl_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

  conv_frame_ctrl #(
    .PIX_W(PIX_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bus(bus), .busy(busy),
    .done(done), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [COEF_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts a frame, feeds pixels whenever ready and counts kernel write cycles until done
  task automatic run_frame(input bit wr_at_start, output int kw, output bit got_done);
    kw = 0; got_done = 1'b0;
    cfg_we = wr_at_start; cfg_addr = 4'd1; cfg_data = 16'd2; start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    bus.src_valid = 1'b1; bus.src_data = 8'h11;
    for (int c = 0; c < 100; c++) begin
      if (bus.conv_kernel_wr) kw++;
      if (done) begin got_done = 1'b1; break; end
      tick();
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.conv_valid_out = 1'b0; bus.conv_px_out = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bus.src_ready, bus.conv_valid_in, bus.conv_kernel_wr, bus.snk_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, bus.src_ready, bus.conv_valid_in, bus.conv_kernel_wr, bus.snk_valid});
    end
    checks++;
    if (bus.conv_kernel_addr !== 4'd0 || bus.conv_kernel_data !== 16'd0 || bus.conv_px_in !== 8'd0 ||
        bus.snk_data !== 8'd0 || in_cnt !== 5'd0 || out_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d data=%0d px=%0d snk=%0d in=%0d out=%0d want all 0",
               bus.conv_kernel_addr, bus.conv_kernel_data, bus.conv_px_in, bus.snk_data, in_cnt, out_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_load;
    for (int k = 0; k < 9; k++) cfg_write(4'(k), 16'(k + 1));
    cfg_write(4'd9, 16'd99);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bus.conv_kernel_wr !== 1'b1 || bus.conv_kernel_addr !== 4'(k) ||
          bus.conv_kernel_data !== 16'(k + 1) || bus.src_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: wr=%b addr=%0d data=%0d rdy=%b want wr=1 addr=%0d data=%0d rdy=0",
                 k, bus.conv_kernel_wr, bus.conv_kernel_addr, bus.conv_kernel_data, bus.src_ready, k, k + 1);
      end
      tick();
    end
    checks++;
    if (bus.conv_kernel_wr !== 1'b0 || bus.src_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_entry: wr=%b rdy=%b busy=%b want 0 1 1", bus.conv_kernel_wr, bus.src_ready, busy);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 16; i++) begin
      bus.src_valid = 1'b1; bus.src_data = 8'(i);
      checks++;
      if (bus.src_ready !== 1'b1 || in_cnt !== 5'(i)) begin
        errors++;
        $display("FAIL stream_ready_%0d: rdy=%b in_cnt=%0d want 1 %0d", i, bus.src_ready, in_cnt, i);
      end
      tick();
      checks++;
      if (bus.conv_valid_in !== 1'b1 || bus.conv_px_in !== 8'(i)) begin
        errors++;
        $display("FAIL stream_px_%0d: vin=%b px=%0d want 1 %0d", i, bus.conv_valid_in, bus.conv_px_in, i);
      end
    end
    bus.src_data = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.src_ready !== 1'b0 || in_cnt !== 5'd16 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_full_%0d: rdy=%b in_cnt=%0d busy=%b want 0 16 1", c, bus.src_ready, in_cnt, busy);
      end
      tick();
      checks++;
      if (bus.conv_valid_in !== 1'b0) begin
        errors++;
        $display("FAIL stream_extra_%0d: vin=%b want 0", c, bus.conv_valid_in);
      end
    end
    bus.src_valid = 1'b0;
  endtask

  // done is expected DRAIN_CYC clock edges after the edge that samples the last core output
  task automatic test_drain;
    int n;
    for (int j = 0; j < 4; j++) begin
      bus.conv_valid_out = 1'b1; bus.conv_px_out = 8'(8'hA0 + j);
      tick();
      checks++;
      if (bus.snk_valid !== 1'b1 || bus.snk_data !== 8'(8'hA0 + j) || out_cnt !== 5'(j + 1)) begin
        errors++;
        $display("FAIL sink_%0d: v=%b data=%h out_cnt=%0d want 1 %h %0d",
                 j, bus.snk_valid, bus.snk_data, out_cnt, 8'hA0 + j, j + 1);
      end
    end
    bus.conv_valid_out = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles want 16", n);
    end
    checks++;
    if (busy !== 1'b0 || in_cnt !== 5'd16 || out_cnt !== 5'd4) begin
      errors++;
      $display("FAIL frame_end: busy=%b in=%0d out=%0d want 0 16 4", busy, in_cnt, out_cnt);
    end
    bus.conv_valid_out = 1'b1; bus.conv_px_out = 8'h55;
    tick();
    bus.conv_valid_out = 1'b0;
    checks++;
    if (done !== 1'b0 || bus.snk_valid !== 1'b0 || out_cnt !== 5'd4) begin
      errors++;
      $display("FAIL idle_drop: done=%b snk_v=%b out=%0d want 0 0 4", done, bus.snk_valid, out_cnt);
    end
  endtask

  task automatic test_snapshot_gaps;
    logic [31:0] gm;
    int sent, recv, n;
    gm = 32'hB56D_9AF3; sent = 0; recv = 0;
    cfg_write(4'd0, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cfg_we = (k == 1); cfg_addr = 4'd2; cfg_data = 16'd12;
      checks++;
      if (bus.conv_kernel_wr !== 1'b1 || bus.conv_kernel_addr !== 4'(k) || bus.conv_kernel_data !== 16'(k + 1)) begin
        errors++;
        $display("FAIL snap_load_%0d: wr=%b addr=%0d data=%0d want 1 %0d %0d",
                 k, bus.conv_kernel_wr, bus.conv_kernel_addr, bus.conv_kernel_data, k, k + 1);
      end
      tick();
    end
    for (int c = 0; c < 80; c++) begin
      if (bus.conv_valid_in === 1'b1) begin
        checks++;
        if (recv >= 16 || bus.conv_px_in !== 8'(40 + recv)) begin
          errors++;
          $display("FAIL gap_px_%0d: px=%0d want %0d", recv, bus.conv_px_in, 40 + recv);
        end
        recv++;
      end
      if (recv >= 16) break;
      cfg_we = (c == 5); cfg_addr = 4'd4; cfg_data = 16'd7;
      bus.src_valid = (sent < 16) && gm[c % 32];
      bus.src_data  = 8'(40 + sent);
      if (bus.src_valid && bus.src_ready) sent++;
      tick();
    end
    cfg_we = 1'b0; bus.src_valid = 1'b0;
    checks++;
    if (recv !== 16 || in_cnt !== 5'd16) begin
      errors++;
      $display("FAIL gap_count: recv=%0d in_cnt=%0d want 16 16", recv, in_cnt);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1 || out_cnt !== 5'd0) begin
      errors++;
      $display("FAIL gap_done: done=%b out_cnt=%0d want 1 0", done, out_cnt);
    end
    tick();
  endtask

  task automatic test_abort;
    logic [15:0] exp;
    bit seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp = (k == 4) ? 16'd7 : (k == 2) ? 16'd12 : 16'(k + 1);
      checks++;
      if (bus.conv_kernel_wr !== 1'b1 || bus.conv_kernel_addr !== 4'(k) || bus.conv_kernel_data !== exp) begin
        errors++;
        $display("FAIL next_load_%0d: wr=%b addr=%0d data=%0d want 1 %0d %0d",
                 k, bus.conv_kernel_wr, bus.conv_kernel_addr, bus.conv_kernel_data, k, exp);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bus.src_valid = 1'b1; bus.src_data = 8'(i);
      tick();
    end
    bus.src_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.src_ready !== 1'b0 || in_cnt !== 5'd5 || bus.conv_valid_in !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stream: busy=%b rdy=%b in=%0d vin=%b done=%b want 0 0 5 0 0",
               busy, bus.src_ready, in_cnt, bus.conv_valid_in, done);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_cnt !== 5'd5) begin
      errors++;
      $display("FAIL abort_no_done: done_seen=%b in_cnt=%0d want 0 5", seen, in_cnt);
    end
    cfg_write(4'd0, 16'd1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.conv_kernel_wr !== 1'b1 || in_cnt !== 5'd0) begin
      errors++;
      $display("FAIL start_beats_abort: busy=%b wr=%b in=%0d want 1 1 0", busy, bus.conv_kernel_wr, in_cnt);
    end
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.conv_kernel_wr !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load: busy=%b wr=%b done=%b want 0 0 0", busy, bus.conv_kernel_wr, done);
    end
  endtask

  task automatic test_reset_mid;
    cfg_write(4'd0, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.conv_kernel_wr !== 1'b0 || bus.conv_kernel_addr !== 4'd0 ||
        bus.conv_kernel_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b wr=%b addr=%0d data=%0d want 0 0 0 0",
               busy, bus.conv_kernel_wr, bus.conv_kernel_addr, bus.conv_kernel_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    int  kw;
    bit  ok;
`ifdef CONV_FRAME_CTRL_KDIRTY_EN
    int  wr_at_start [5] = '{0, 0, 1, 0, 0};
    int  exp_kw      [5] = '{9, 0, 9, 9, 0};
    for (int f = 0; f < 5; f++) begin
      if (f == 2) cfg_write(4'd3, 16'd4);
      run_frame(wr_at_start[f] != 0, kw, ok);
      checks++;
      if (kw !== exp_kw[f] || ok !== 1'b1) begin
        errors++;
        $display("FAIL kdirty_frame_%0d: kernel_wr cycles=%0d done=%b want %0d 1", f, kw, ok, exp_kw[f]);
      end
    end
`else
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b0, kw, ok);
      checks++;
      if (kw !== 9 || ok !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame_%0d: kernel_wr cycles=%0d done=%b want 9 1", f, kw, ok);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_drain();
    test_snapshot_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
